vxe_txnreqa_decoder: RTL
========================

# vxe_txnreqa_decoder

Receiving end of the 44-bit address-only request transaction vector (`{txnid[5:0], rnw, addr[36:0]}`). The block accepts encoded vectors through a valid/ready port into a 2-entry input buffer. It decodes each vector and dispatches it, in arrival order, to a registered read channel or write channel, and counts dispatched transactions per direction. It sits on the memory-request side of the VxEngine, between request-vector producers and the bus master read/write request ports.

## Interface

- CNT_WIDTH, 16, width of the per-direction dispatch counters
- clk  in  1  clock
- nrst  in  1  reset; asynchronous, active-low
- i_req_vec  in  44  encoded request vector: [43:38] txnid, [37] rnw (1=read), [36:0] upper 37 bits of 40-bit address
- i_req_vld  in  1  input vector valid
- o_req_rdy  out  1  input buffer can accept
- o_rd_txnid  out  6  read transaction id
- o_rd_addr  out  40  read address `{addr, 3'b000}`
- o_rd_vld  out  1  read request valid
- i_rd_rdy  in  1  read request accepted
- o_wr_txnid  out  6  write transaction id
- o_wr_addr  out  40  write address `{addr, 3'b000}`
- o_wr_vld  out  1  write request valid
- i_wr_rdy  in  1  write request accepted
- i_cnt_clr  in  1  synchronous clear of both counters
- o_rd_cnt  out  CNT_WIDTH  read requests dispatched (output handshakes)
- o_wr_cnt  out  CNT_WIDTH  write requests dispatched

## Operation

- Reset values: o_req_rdy=0, o_rd_vld=0, o_wr_vld=0, o_rd_txnid/o_wr_txnid=0, o_rd_addr/o_wr_addr=0, o_rd_cnt=0, o_wr_cnt=0, input buffer empty.
- Input buffer is a 2-entry FIFO with a registered occupancy count of 0..2.
  - o_req_rdy is registered and equals (next occupancy < 2).
  - An input handshake is i_req_vld & o_req_rdy and pushes i_req_vec.
- Dispatch takes the head entry only:
  - rnw=1 targets the read channel; rnw=0 targets the write channel.
  - The head moves into the target output register when that register is empty, or is emptied in the same cycle (o_x_vld & i_x_rdy).
  - Strict in-order: if the head's target channel is blocked, nothing is dispatched, even if the other channel is free.
- Output registers hold txnid and addr stable while o_x_vld=1 and i_x_rdy=0.
  - On a handshake with no new dispatch, o_x_vld drops; data values are don't-care but hold their last value.
- Simultaneous push and pop are legal at any occupancy, including full. Occupancy is unchanged, and o_req_rdy is computed from the net result.
- Counters:
  - Each counter increments on its output handshake and wraps modulo 2^CNT_WIDTH (all-ones → 0).
  - i_cnt_clr has priority: a clear in the same cycle as a handshake yields 0, and that handshake is not counted.
- Reset mid-operation discards buffered and presented requests immediately. Counters clear.

## Timing

- Latency: a vector accepted at edge N, into an empty buffer with a free target channel, shows o_x_vld=1 after edge N+1.
- Sustained throughput is 1 vector/cycle for any rd/wr mix while downstream ready stays high.
- o_req_rdy becomes 1 on the first clk rising edge after nrst deasserts.
- There are no combinational paths from i_rd_rdy/i_wr_rdy/i_req_vld to o_req_rdy; all outputs are registered.
- Backpressure: with a channel stalled and its output register full, the buffer fills after 2 more head-targeted vectors, and o_req_rdy=0 on the following cycle.

## Test plan

- Single read: i_req_vec={6'h2A,1'b1,37'h1_2345_6789} pulsed, i_rd_rdy=1 → one cycle later o_rd_vld=1, o_rd_txnid=6'h2A, o_rd_addr=40'h91_A2B3_C48; o_wr_vld stays 0; o_rd_cnt=1.
- Back-to-back alternation: 8 vectors alternating rd/wr, txnid 0..7, both rdy=1 → 8 dispatches on consecutive cycles in order; o_req_rdy never drops; o_rd_cnt=4, o_wr_cnt=4.
- Head-of-line blocking: i_wr_rdy=0, send wr(id 1), wr(id 2), rd(id 3), rd(id 4) → write channel holds id 1; buffer holds id 2 and id 3; o_req_rdy=0; id 3 is not dispatched while the read channel is idle. Releasing i_wr_rdy then yields dispatch order 1, 2, 3, 4.
- Full-buffer push+pop: occupancy 2 with a pop and push in the same cycle → occupancy stays 2; no vector is lost or duplicated (checked by txnid sequence).
- Counter wrap/clear: CNT_WIDTH=4, 16 reads → o_rd_cnt=0. i_cnt_clr asserted in the same cycle as a write handshake → o_wr_cnt=0.
- Async reset with 2 buffered entries and both o_x_vld=1: nrst low mid-cycle → all valids and counters are 0 immediately. After release, o_req_rdy=1 at the next edge, and no stale dispatch occurs.

Source files
------------

// File: rtl/vxe_txnreqa_decoder.sv
// Request-vector decoder: 2-entry input FIFO feeding in-order read/write
// output registers, with per-direction dispatch counters.
module vxe_txnreqa_decoder #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [43:0]          i_req_vec,
    input  logic                 i_req_vld,
    output logic                 o_req_rdy,
    output logic [5:0]           o_rd_txnid,
    output logic [39:0]          o_rd_addr,
    output logic                 o_rd_vld,
    input  logic                 i_rd_rdy,
    output logic [5:0]           o_wr_txnid,
    output logic [39:0]          o_wr_addr,
    output logic                 o_wr_vld,
    input  logic                 i_wr_rdy,
    input  logic                 i_cnt_clr,
    output logic [CNT_WIDTH-1:0] o_rd_cnt,
    output logic [CNT_WIDTH-1:0] o_wr_cnt
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [43:0]          buf_r [2];
    logic                 wr_ptr_r;
    logic                 rd_ptr_r;
    logic [1:0]           occ_r;
    logic                 req_rdy_r;
    logic [5:0]           rd_txnid_r;
    logic [39:0]          rd_addr_r;
    logic                 rd_vld_r;
    logic [5:0]           wr_txnid_r;
    logic [39:0]          wr_addr_r;
    logic                 wr_vld_r;
    logic [CNT_WIDTH-1:0] rd_cnt_r;
    logic [CNT_WIDTH-1:0] wr_cnt_r;

    logic [43:0]          head_s;
    logic                 head_vld_s;
    logic                 head_rnw_s;
    logic                 rd_hs_s;
    logic                 wr_hs_s;
    logic                 rd_load_s;
    logic                 wr_load_s;
    logic                 push_s;
    logic                 pop_s;
    logic [1:0]           occ_nxt_s;

    // Head decode and dispatch decision; a blocked head stalls both channels
    always_comb begin
        head_s     = buf_r[rd_ptr_r];
        head_vld_s = (occ_r != 2'd0);
        head_rnw_s = head_s[37];
        rd_hs_s    = rd_vld_r & i_rd_rdy;
        wr_hs_s    = wr_vld_r & i_wr_rdy;
        rd_load_s  = head_vld_s &  head_rnw_s & (~rd_vld_r | i_rd_rdy);
        wr_load_s  = head_vld_s & ~head_rnw_s & (~wr_vld_r | i_wr_rdy);
        pop_s      = rd_load_s | wr_load_s;
        push_s     = i_req_vld & req_rdy_r;
        occ_nxt_s  = occ_r + {1'b0, push_s} - {1'b0, pop_s};
    end

    // Input FIFO storage, pointers, occupancy and registered ready
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            buf_r[0]  <= 44'd0;
            buf_r[1]  <= 44'd0;
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            occ_r     <= 2'd0;
            req_rdy_r <= 1'b0;
        end else begin
            // When full, a push overwrites the slot being popped this cycle
            if (push_s) begin
                buf_r[wr_ptr_r] <= i_req_vec;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            occ_r     <= occ_nxt_s;
            req_rdy_r <= (occ_nxt_s < 2'd2);
        end
    end

    // Read and write output registers; data holds until the next load
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_vld_r   <= 1'b0;
            rd_txnid_r <= 6'd0;
            rd_addr_r  <= 40'd0;
            wr_vld_r   <= 1'b0;
            wr_txnid_r <= 6'd0;
            wr_addr_r  <= 40'd0;
        end else begin
            if (rd_load_s) begin
                rd_vld_r   <= 1'b1;
                rd_txnid_r <= head_s[43:38];
                rd_addr_r  <= {head_s[36:0], 3'b000};
            end else if (rd_hs_s) begin
                rd_vld_r <= 1'b0;
            end
            if (wr_load_s) begin
                wr_vld_r   <= 1'b1;
                wr_txnid_r <= head_s[43:38];
                wr_addr_r  <= {head_s[36:0], 3'b000};
            end else if (wr_hs_s) begin
                wr_vld_r <= 1'b0;
            end
        end
    end

    // Dispatch counters; clear wins over a same-cycle handshake
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_cnt_r <= '0;
            wr_cnt_r <= '0;
        end else if (i_cnt_clr) begin
            rd_cnt_r <= '0;
            wr_cnt_r <= '0;
        end else begin
            if (rd_hs_s) begin
                rd_cnt_r <= rd_cnt_r + CNT_ONE;
            end
            if (wr_hs_s) begin
                wr_cnt_r <= wr_cnt_r + CNT_ONE;
            end
        end
    end

    assign o_req_rdy  = req_rdy_r;
    assign o_rd_txnid = rd_txnid_r;
    assign o_rd_addr  = rd_addr_r;
    assign o_rd_vld   = rd_vld_r;
    assign o_wr_txnid = wr_txnid_r;
    assign o_wr_addr  = wr_addr_r;
    assign o_wr_vld   = wr_vld_r;
    assign o_rd_cnt   = rd_cnt_r;
    assign o_wr_cnt   = wr_cnt_r;

endmodule
